mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the CPU's single-port memory between the instruction-fetch path and the execute path (loads and stores). The arbiter sequences each access over a fixed number of memory wait cycles and signals the owning requester on completion. The control unit uses the per-requester `done` pulses to advance its microsequence, and stalls on `busy`. Grants alternate round-robin so that a stream of data accesses cannot starve instruction fetch, and the reverse.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: memory data width.
- `WAIT_CYCLES`, default 2: cycles `mem_en` is held per access. Legal range is 1..15.

Ports:
- `clk` input 1: single clock; everything updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_req` input 1: instruction-fetch read request.
- `if_addr` input ADDR_W: fetch address.
- `if_gnt` output 1: fetch owns the memory.
- `if_rdata` output DATA_W: last fetched word.
- `if_done` output 1: one-cycle completion pulse for fetch.
- `ex_req` input 1: execute request.
- `ex_we` input 1: 1 = store, 0 = load.
- `ex_addr` input ADDR_W: execute address.
- `ex_wdata` input DATA_W: store data.
- `ex_gnt` output 1: execute owns the memory.
- `ex_rdata` output DATA_W: last loaded word.
- `ex_done` output 1: one-cycle completion pulse for execute.
- `mem_en` output 1: memory access enable.
- `mem_we` output 1: memory write enable.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data.
- `busy` output 1: FSM not in IDLE.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE:**
  - Samples `if_req` and `ex_req`.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not granted last wins. `last` resets to EX, so IF wins the first tie after reset.
  - On a win, at the edge: state goes to ACCESS, `owner` and `last` are updated, `cnt` is set to WAIT_CYCLES-1, and the winner's `gnt` is set to 1.
  - Also at that edge: `mem_en` is set to 1, and `mem_we`, `mem_addr` and `mem_wdata` are registered from the winner. For IF, `mem_we` is 0 and `mem_wdata` is 0.
- **ACCESS:**
  - All `mem_*` outputs and the winner's `gnt` are held stable.
  - If `cnt != 0`, `cnt` decrements.
  - If `cnt == 0`, at the edge: `mem_en` and `mem_we` are cleared and state goes to RESP.
  - At that same edge, a read captures `mem_rdata` into the owner's `rdata`. A store leaves `ex_rdata` unchanged.
- **RESP:**
  - The owner's `done` is 1 for exactly this cycle, and `gnt` stays 1.
  - At the next edge, `gnt` is cleared and state returns to IDLE.
  - Requests are not sampled in RESP.
- Requesters must hold `req`, address and data stable until `done`. Dropping `req` mid-transaction does not abort it; the access completes and `done` still pulses.
- A requester that keeps `req` high through `done` is treated as a new request in the following IDLE cycle.
- `if_rdata` and `ex_rdata` hold their values between reads.
- At most one `gnt` is high in any cycle. `if_done` and `ex_done` are never high together.
- `busy` equals (state != IDLE).
- `cnt` is 4 bits. Values of WAIT_CYCLES outside 1..15 are illegal; this is checked in simulation only.

## Timing
- **Reset:** When `rst` is 1 at an edge, the following take effect at that edge, regardless of the current state:
  - state = IDLE, `last` = EX, `cnt` = 0.
  - `if_gnt`, `ex_gnt`, `if_done`, `ex_done`, `mem_en`, `mem_we`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `ex_rdata` = 0.
- **Reset mid-ACCESS:** `mem_en` drops at the reset edge and the in-flight access is abandoned with no `done`. A store in progress may or may not have been written.
- **Latency:** Let E0 be the edge at which IDLE samples `req`.
  - `mem_en` is high from E0 through E0+WAIT_CYCLES.
  - Read data is sampled at edge E0+WAIT_CYCLES, so memory must drive `mem_rdata` within WAIT_CYCLES cycles of `mem_en` rising.
  - `done` is high in the cycle after E0+WAIT_CYCLES.
  - The arbiter is back in IDLE after E0+WAIT_CYCLES+1.
- **Throughput:** at most one transaction every WAIT_CYCLES+2 cycles. With WAIT_CYCLES=2 that is one per 4 cycles.
- **Simultaneous events:** a request arriving while the arbiter is in RESP is seen at the next IDLE edge and is not lost, provided it stays held.
- **Combinational paths:** none from inputs to outputs. All outputs are registered, except `busy`, which is decoded from the state register.

## Test plan
- **Reset:** reset asserted for 3 cycles with both requests high. Required: all outputs 0 throughout; the first grant after release goes to IF.
- **Single IF read (WAIT_CYCLES=2):** `if_req` with `if_addr`=0x10; memory returns 0xA5. Required: `mem_en` high for 2 cycles with `mem_addr`=0x10 and `mem_we`=0; `if_done` pulses 3 cycles after E0; `if_rdata`=0xA5; `ex_gnt` stays 0.
- **EX store:** `ex_we`=1, `ex_addr`=0x20, `ex_wdata`=0x3C. Required: `mem_we`=1 and `mem_wdata`=0x3C for 2 cycles; `ex_done` pulses once; `ex_rdata` unchanged.
- **Contention:** both requests held continuously for 4 transactions. Required: grants run IF, EX, IF, EX, one `done` every 4 cycles, and never both `gnt` high.
- **Abort attempt:** `if_req` dropped one cycle after the grant. Required: the access still completes and `if_done` still pulses.
- **Reset mid-ACCESS:** reset asserted during an EX load. Required: `mem_en`, `ex_gnt` and `busy` are 0 at the next edge; no `ex_done`; `ex_rdata`=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between instruction fetch
// and execute. Each access holds mem_en for WAIT_CYCLES, then pulses done.
module mem_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_gnt,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] cnt_r;
  logic       last_r;     // 1: execute was granted most recently
  logic       owner_r;    // 1: execute owns the current access
  logic       win_s;
  logic       win_ex_s;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_arbiter: WAIT_CYCLES must lie in 1..15");
  end

  // Pick a winner among the pending requests; ties go to whoever waited.
  always_comb begin
    win_s    = 1'b0;
    win_ex_s = 1'b0;
    if (if_req && ex_req) begin
      win_s    = 1'b1;
      win_ex_s = ~last_r;
    end else if (if_req) begin
      win_s    = 1'b1;
      win_ex_s = 1'b0;
    end else if (ex_req) begin
      win_s    = 1'b1;
      win_ex_s = 1'b1;
    end else begin
      win_s    = 1'b0;
      win_ex_s = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_s) next_state_s = ACCESS;
        else       next_state_s = IDLE;
      end
      ACCESS: begin
        if (cnt_r == 4'd0) next_state_s = RESP;
        else               next_state_s = ACCESS;
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Registered memory interface, grants, completion pulses and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 4'd0;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      if_gnt    <= 1'b0;
      ex_gnt    <= 1'b0;
      if_done   <= 1'b0;
      ex_done   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      if_rdata  <= {DATA_W{1'b0}};
      ex_rdata  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (win_s) begin
            owner_r <= win_ex_s;
            last_r  <= win_ex_s;
            cnt_r   <= CNT_INIT;
            mem_en  <= 1'b1;
            if (win_ex_s) begin
              ex_gnt    <= 1'b1;
              mem_we    <= ex_we;
              mem_addr  <= ex_addr;
              mem_wdata <= ex_wdata;
            end else begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_r) begin
              ex_done <= 1'b1;
              if (!mem_we) ex_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          if_gnt  <= 1'b0;
          ex_gnt  <= 1'b0;
          if_done <= 1'b0;
          ex_done <= 1'b0;
        end
        default: begin
          if_gnt  <= 1'b0;
          ex_gnt  <= 1'b0;
          if_done <= 1'b0;
          ex_done <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-timing model plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, ex_req = 1'b0, ex_we = 1'b0;
  logic [AW-1:0] if_addr = 8'h00, ex_addr = 8'h00;
  logic [DW-1:0] ex_wdata = 8'h00;
  logic          if_gnt, if_done, ex_gnt, ex_done, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, ex_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_done(if_done),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(ex_gnt), .ex_rdata(ex_rdata), .ex_done(ex_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h10)      return 8'hA5;
    else if (a == 8'h30) return 8'h5A;
    else                 return a ^ 8'h5A;
  endfunction

  // Memory: data valid only once mem_en has been high WAIT-1 cycles, junk before.
  logic [7:0] tb_mem [256];
  bit         tb_wr  [256];
  int         en_cnt = 0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      tb_wr[mem_addr]  <= 1'b1;
    end
    en_cnt <= mem_en ? en_cnt + 1 : 0;
  end
  assign mem_rdata = (mem_en && en_cnt >= WAIT - 1)
                   ? (tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr)) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a transaction started at edge s owns edges s..s+WAIT, done on s+WAIT,
  // and the arbiter samples again at s+WAIT+2.
  int         edge_n = 0;
  int         start_e = 0;
  bit         model_valid = 1'b0;
  bit         m_active = 1'b0, m_ex = 1'b0, m_we = 1'b0, last_ex = 1'b1;
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00;
  logic [7:0] e_if_rdata = 8'h00, e_ex_rdata = 8'h00;
  logic [7:0] exp_store [int];
  bit         m_grants [$];
  bit         dut_grants [$];

  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_valid = 1'b1;
      m_active    = 1'b0;
      last_ex     = 1'b1;
      e_if_rdata  = 8'h00;
      e_ex_rdata  = 8'h00;
    end else begin
      if (m_active && edge_n == start_e + WAIT) begin
        if (m_ex && m_we) exp_store[int'(m_addr)] = m_wdata;
        else if (m_ex)    e_ex_rdata = exp_store.exists(int'(m_addr)) ? exp_store[int'(m_addr)] : init_val(m_addr);
        else              e_if_rdata = exp_store.exists(int'(m_addr)) ? exp_store[int'(m_addr)] : init_val(m_addr);
      end
      if (!m_active || edge_n >= start_e + WAIT + 2) begin
        if (if_req || ex_req) begin
          m_ex     = (if_req && ex_req) ? !last_ex : ex_req;
          last_ex  = m_ex;
          m_active = 1'b1;
          start_e  = edge_n;
          m_we     = m_ex ? ex_we : 1'b0;
          m_addr   = m_ex ? ex_addr : if_addr;
          m_wdata  = m_ex ? ex_wdata : 8'h00;
          m_grants.push_back(m_ex);
        end else begin
          m_active = 1'b0;
        end
      end
    end
  end

  // Compare every cycle against the model.
  bit prev_if_gnt = 1'b0, prev_ex_gnt = 1'b0;
  initial forever begin
    int d;
    bit in_tx, e_en;
    @(negedge clk);
    if (model_valid) begin
      d     = edge_n - start_e;
      in_tx = m_active && d >= 0 && d <= WAIT;
      e_en  = in_tx && d < WAIT;
      check("if_gnt",   if_gnt,   in_tx && !m_ex);
      check("ex_gnt",   ex_gnt,   in_tx && m_ex);
      check("if_done",  if_done,  in_tx && !m_ex && d == WAIT);
      check("ex_done",  ex_done,  in_tx && m_ex && d == WAIT);
      check("mem_en",   mem_en,   e_en);
      check("mem_we",   mem_we,   e_en && m_we);
      check("busy",     busy,     in_tx);
      check("if_rdata", if_rdata, e_if_rdata);
      check("ex_rdata", ex_rdata, e_ex_rdata);
      if (e_en) begin
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
      end
      if (if_gnt && !prev_if_gnt) dut_grants.push_back(1'b0);
      if (ex_gnt && !prev_ex_gnt) dut_grants.push_back(1'b1);
      prev_if_gnt = if_gnt;
      prev_ex_gnt = ex_gnt;
    end
  end

  task automatic do_txn(input bit ex, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, input bit abort, output int lat, output int ens);
    bit seen;
    seen = 1'b0; lat = 0; ens = 0;
    @(negedge clk);
    if (ex) begin
      ex_req = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_en) ens++;
      if (abort && i == 1) begin
        if_req = 1'b0;
        ex_req = 1'b0;
      end
      if (ex ? ex_done : if_done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if_req = 1'b0;
    ex_req = 1'b0;
    check("done_seen", seen, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    int lat, ens, base_d, base_m, dones, last_t;
    bit ok;
    // Reset with both requests asserted.
    if_req = 1'b1;
    ex_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ctrl", {if_gnt, ex_gnt, if_done, ex_done, mem_en, mem_we, busy}, 7'd0);
      check("rst_data", {mem_addr, mem_wdata, if_rdata, ex_rdata}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_gnt_if", if_gnt, 1'b1);
    check("first_gnt_ex", ex_gnt, 1'b0);
    if_req = 1'b0;
    ex_req = 1'b0;
    wait_idle();

    // Single fetch.
    do_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, ens);
    check("if_latency", lat, 3);
    check("if_en_cycles", ens, 2);
    check("if_rdata_a5", if_rdata, 8'hA5);

    // Load, store, reload through execute.
    do_txn(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, lat, ens);
    check("ex_load_5a", ex_rdata, 8'h5A);
    do_txn(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, lat, ens);
    check("st_en_cycles", ens, 2);
    check("st_latency", lat, 3);
    check("st_rdata_kept", ex_rdata, 8'h5A);
    do_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, lat, ens);
    check("ex_reload_3c", ex_rdata, 8'h3C);

    // Contention: both requests held for four transactions.
    @(negedge clk);
    base_d = dut_grants.size();
    base_m = m_grants.size();
    if_req = 1'b1; if_addr = 8'h40;
    ex_req = 1'b1; ex_addr = 8'h50; ex_we = 1'b0;
    dones = 0; last_t = 0; ok = 1'b1;
    for (int t = 1; t <= 40 && dones < 4; t++) begin
      @(negedge clk);
      if (if_done || ex_done) begin
        if (dones > 0 && t - last_t != 4) ok = 1'b0;
        last_t = t;
        dones++;
      end
    end
    if_req = 1'b0;
    ex_req = 1'b0;
    check("cont_dones", dones, 4);
    check("cont_spacing", ok, 1'b1);
    check("cont_ngrants", dut_grants.size() - base_d, 4);
    for (int k = 0; k < 4; k++) begin
      check("cont_dut_order", (base_d + k < dut_grants.size()) ? dut_grants[base_d + k] : 1'bx, k % 2);
      check("cont_model_order", (base_m + k < m_grants.size()) ? m_grants[base_m + k] : 1'bx, k % 2);
    end

    // Dropping the request after the grant does not abort the access.
    do_txn(1'b0, 1'b0, 8'h11, 8'h00, 1'b1, lat, ens);
    check("abort_latency", lat, 3);
    check("abort_rdata", if_rdata, 8'h11 ^ 8'h5A);

    // Reset in the middle of an execute load.
    @(negedge clk);
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 8'h30;
    @(negedge clk);
    check("mid_ex_gnt", ex_gnt, 1'b1);
    rst = 1'b1;
    ex_req = 1'b0;
    @(negedge clk);
    check("mid_rst_en", mem_en, 1'b0);
    check("mid_rst_gnt", ex_gnt, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rdata", ex_rdata, 8'h00);
    rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ex_done) ok = 1'b0;
    end
    check("mid_rst_no_done", ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
